// File: rtl/spi_flash_loader.sv
// spi_flash_loader
//   Boot-time SPI flash initiator. Issues a single-bit READ (0x03) at
//   BASE_ADDR and streams NUM_WORDS little-endian 32-bit words into the
//   core's instruction memory. The core is held in reset until the image
//   is in place.
//
// Ports
//   clock, resetb      system clock, asynchronous active-low reset
//   start              level-sampled (re)load request, honoured in IDLE/DONE
//   flash_csb          flash chip select, active low
//   flash_clk          SPI clock, mode 0 (idles low)
//   flash_io0          MOSI
//   flash_io1          MISO
//   imem_we            one-cycle instruction-memory write strobe
//   imem_addr          word address of the write
//   imem_wdata         write data
//   busy               load in progress
//   done               image loaded
//   core_resetb        active-low reset to the user core
module spi_flash_loader #(
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int          NUM_WORDS  = 64,
  parameter int          IMEM_AW    = 6,
  parameter int          CLK_DIV    = 2,
  parameter int          AUTO_START = 1
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               start,
  output logic               flash_csb,
  output logic               flash_clk,
  output logic               flash_io0,
  input  logic               flash_io1,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               core_resetb
);

  localparam logic [31:0]        HEADER    = {8'h03, BASE_ADDR};
  localparam int                 DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IMEM_AW-1:0] LAST_WORD = IMEM_AW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_HDR,
    SHIFT_DATA,
    WRITE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic               auto_pending;   // high only in the first cycle after reset
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;        // bit position within header or word
  logic [31:0]        tx_sr;          // header bits still to be sent
  logic [31:0]        rx_sr;          // received bits, first byte ends up in [31:24]
  logic [IMEM_AW-1:0] word_idx;

  logic init;     // first cycle of a load: outputs leave their idle values
  logic running;  // SPI clock generator active
  logic tick;     // half-period elapsed
  logic rise;     // flash_clk goes high this edge: sample io1
  logic fall;     // flash_clk goes low this edge: advance io0

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    init    = (state_q == SHIFT_HDR) && flash_csb;
    running = (state_q inside {SHIFT_HDR, SHIFT_DATA, WRITE}) && !flash_csb;
    tick    = (div_cnt == DIV_LAST);
    rise    = running && tick && !flash_clk;
    fall    = running && tick && flash_clk;
    state_d = state_q;

    case (state_q)
      IDLE:       if (start || auto_pending) state_d = SHIFT_HDR;
      SHIFT_HDR:  if (rise && bit_cnt == 5'd31) state_d = SHIFT_DATA;
      SHIFT_DATA: if (rise && bit_cnt == 5'd31) state_d = WRITE;
      WRITE:      state_d = (word_idx == LAST_WORD) ? DONE : SHIFT_DATA;
      // busy is still high in the first DONE cycle, while the outputs wind down
      DONE:       if (!busy && start) state_d = SHIFT_HDR;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      auto_pending <= (AUTO_START != 0);
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      word_idx     <= '0;
      flash_csb    <= 1'b1;
      flash_clk    <= 1'b0;
      flash_io0    <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      core_resetb  <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_pending <= 1'b0;
      imem_we      <= 1'b0;

      if (init) begin
        flash_csb   <= 1'b0;
        flash_clk   <= 1'b0;
        flash_io0   <= HEADER[31];
        tx_sr       <= {HEADER[30:0], 1'b0};
        div_cnt     <= '0;
        bit_cnt     <= '0;
        word_idx    <= '0;
        imem_addr   <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
        core_resetb <= 1'b0;
      end else if (running) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) flash_clk <= ~flash_clk;
        if (rise) begin
          rx_sr   <= {rx_sr[30:0], flash_io1};
          bit_cnt <= bit_cnt + 5'd1;
        end
        // After the header the shifter has drained to zero, so io0 stays low.
        if (fall) begin
          flash_io0 <= tx_sr[31];
          tx_sr     <= {tx_sr[30:0], 1'b0};
        end
        if (state_q == WRITE) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx;
          imem_wdata <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
          word_idx   <= word_idx + 1'b1;
        end
      end else if (state_q == DONE && busy) begin
        // Close the transfer; any pending flash_clk edge is dropped.
        flash_csb   <= 1'b1;
        flash_clk   <= 1'b0;
        flash_io0   <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        core_resetb <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_loader.sv
// tb_spi_flash_loader
//   Two loaders share one flash image:
//     u_dut0: BASE 0x000000, 8 words into an 8-entry memory (address wrap),
//             CLK_DIV=2, auto start after reset
//     u_dut1: BASE 0x000100, 1 word, CLK_DIV=1, started by request
//   A flash model answers READ commands from a random image; writes are
//   checked against words assembled directly from that image and against
//   the expected cycle of each write relative to the start edge.
module tb_spi_flash_loader;

  localparam int          CD0 = 2;
  localparam int          NW0 = 8;
  localparam int          AW0 = 3;
  localparam logic [23:0] BA0 = 24'h000000;
  localparam int          CD1 = 1;
  localparam int          NW1 = 1;
  localparam int          AW1 = 6;
  localparam logic [23:0] BA1 = 24'h000100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           resetb [2];
  logic           start  [2];
  logic           io1    [2] = '{1'b0, 1'b0};
  logic           csb    [2];
  logic           fclk   [2];
  logic           io0    [2];
  logic           we     [2];
  logic           busy   [2];
  logic           done   [2];
  logic           core_rb[2];
  logic [31:0]    wdata  [2];
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;

  spi_flash_loader #(
    .BASE_ADDR(BA0), .NUM_WORDS(NW0), .IMEM_AW(AW0), .CLK_DIV(CD0), .AUTO_START(1)
  ) u_dut0 (
    .clock(clock), .resetb(resetb[0]), .start(start[0]),
    .flash_csb(csb[0]), .flash_clk(fclk[0]), .flash_io0(io0[0]), .flash_io1(io1[0]),
    .imem_we(we[0]), .imem_addr(addr0), .imem_wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .core_resetb(core_rb[0])
  );

  spi_flash_loader #(
    .BASE_ADDR(BA1), .NUM_WORDS(NW1), .IMEM_AW(AW1), .CLK_DIV(CD1), .AUTO_START(0)
  ) u_dut1 (
    .clock(clock), .resetb(resetb[1]), .start(start[1]),
    .flash_csb(csb[1]), .flash_clk(fclk[1]), .flash_io0(io0[1]), .flash_io1(io1[1]),
    .imem_we(we[1]), .imem_addr(addr1), .imem_wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .core_resetb(core_rb[1])
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash image and reference helpers
  logic [7:0] fmem [0:2047];

  function automatic logic [31:0] exp_word(input logic [23:0] base, input int w);
    int a = int'(base) + 4 * w;
    return {fmem[(a + 3) % 2048], fmem[(a + 2) % 2048], fmem[(a + 1) % 2048], fmem[a % 2048]};
  endfunction

  function automatic logic flash_bit(input logic [23:0] base, input int b);
    logic [7:0] by = fmem[(int'(base) + b / 8) % 2048];
    return by[7 - (b % 8)];
  endfunction

  // Flash model + write monitor, sampled mid-cycle
  int          nbits [2] = '{0, 0};
  int          obit  [2] = '{0, 0};
  int          rises [2] = '{0, 0};
  logic [31:0] hdr   [2] = '{32'h0, 32'h0};
  logic        pclk  [2] = '{1'b0, 1'b0};
  logic        pcsb  [2] = '{1'b1, 1'b1};
  int          wa    [2][$];
  logic [31:0] wd    [2][$];
  int          wcy   [2][$];
  logic [31:0] imem0 [0:NW0-1];

  always @(negedge clock) begin
    if (!resetb[0]) for (int k = 0; k < NW0; k++) imem0[k] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      if (pcsb[i] && !csb[i]) begin
        nbits[i] = 0; obit[i] = 0; rises[i] = 0; hdr[i] = 32'h0;
      end
      if (!csb[i]) begin
        if (fclk[i] && !pclk[i]) begin
          rises[i]++;
          if (nbits[i] < 32) begin
            hdr[i] = {hdr[i][30:0], io0[i]};
            nbits[i]++;
          end
        end
        if (!fclk[i] && pclk[i] && nbits[i] == 32) begin
          io1[i] = flash_bit(hdr[i][23:0], obit[i]);
          obit[i]++;
        end
      end
      pclk[i] = fclk[i];
      pcsb[i] = csb[i];
      if (we[i]) begin
        wa[i].push_back((i == 0) ? int'(addr0) : int'(addr1));
        wd[i].push_back(wdata[i]);
        wcy[i].push_back(cyc);
        if (i == 0) imem0[addr0] = wdata[0];
      end
    end
  end

  task automatic wait_done(input int i, input int budget, output int t_done);
    int k = 0;
    while (!done[i] && k < budget) begin
      @(negedge clock);
      k++;
    end
    t_done = cyc;
    check($sformatf("done%0d_reached", i), done[i], 1'b1);
  endtask

  // Checks one complete load that started at edge t0, using writes logged from index first.
  task automatic check_run(input int i, input int t0, input int first, input int t_done, input string tag);
    int          nw   = (i == 0) ? NW0 : NW1;
    int          cd   = (i == 0) ? CD0 : CD1;
    logic [23:0] base = (i == 0) ? BA0 : BA1;
    check({tag, "_count"}, wa[i].size() - first, nw);
    check({tag, "_hdr"}, hdr[i], {8'h03, base});
    check({tag, "_rises"}, rises[i], 32 + 32 * nw);
    for (int w = 0; w < nw; w++) begin
      if (first + w < wa[i].size()) begin
        check($sformatf("%s_addr%0d", tag, w), wa[i][first + w], w);
        check($sformatf("%s_data%0d", tag, w), wd[i][first + w], exp_word(base, w));
        check($sformatf("%s_cyc%0d", tag, w), wcy[i][first + w], t0 + 2 + 127 * cd + 64 * cd * w);
      end
    end
    if (wa[i].size() > first)
      check({tag, "_done_lat"}, t_done, wcy[i][wa[i].size() - 1] + 1);
    check({tag, "_flags"}, {csb[i], fclk[i], busy[i], done[i], core_rb[i]}, 5'b10011);
  endtask

  int t0;
  int td;
  int idx;

  initial begin
    resetb[0] = 1'b0; resetb[1] = 1'b0;
    start[0]  = 1'b0; start[1]  = 1'b0;
    for (int k = 0; k < 2048; k++) fmem[k] = 8'($urandom);
    fmem[0] = 8'h13; fmem[1] = 8'h00; fmem[2] = 8'h00; fmem[3] = 8'h00;
    fmem[4] = 8'h93; fmem[5] = 8'h00; fmem[6] = 8'h10; fmem[7] = 8'h00;

    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset%0d", i),
            {csb[i], fclk[i], io0[i], we[i], busy[i], done[i], core_rb[i], wdata[i]},
            {7'b1000000, 32'h0});
    check("reset_addr", {addr0, addr1}, '0);

    // Auto start: the first edge after release is the start edge.
    resetb[0] = 1'b1; resetb[1] = 1'b1;
    t0 = cyc + 1;
    repeat (2) @(negedge clock);
    check("auto_t1", {csb[0], busy[0], done[0], core_rb[0], io0[0]}, 5'b01000);
    check("idle1", {csb[1], busy[1], done[1]}, 3'b100);

    // A start request while busy must change nothing.
    repeat ($urandom_range(20, 400)) @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    wait_done(0, 3000, td);
    check_run(0, t0, 0, td, "load0");
    check("load0_word0", wd[0][0], 32'h00000013);
    check("load0_word1", wd[0][1], 32'h00100093);

    // Requested load on the second loader (CLK_DIV=1, offset 0x100).
    start[1] = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    start[1] = 1'b0;
    @(negedge clock);
    check("load1_t1", {csb[1], busy[1]}, 2'b01);
    wait_done(1, 500, td);
    check_run(1, t0, 0, td, "load1");

    // Reload from DONE.
    idx = wa[0].size();
    start[0] = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    start[0] = 1'b0;
    @(negedge clock);
    check("reload_t1", {done[0], core_rb[0], busy[0], csb[0]}, 4'b0010);
    wait_done(0, 3000, td);
    check_run(0, t0, idx, td, "reload0");

    // Reset during SHIFT_DATA of word 3, then the automatic restart.
    idx = wa[0].size();
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    for (int k = 0; k < 2000 && wa[0].size() < idx + 3; k++) @(negedge clock);
    check("midrst_w3", wa[0].size() - idx, 3);
    repeat (40) @(negedge clock);
    #2 resetb[0] = 1'b0;
    #1 check("midrst_out", {csb[0], core_rb[0], busy[0], done[0], fclk[0], we[0]}, 6'b100000);
    repeat (2) @(negedge clock);
    idx = wa[0].size();
    resetb[0] = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    wait_done(0, 3000, td);
    check_run(0, t0, idx, td, "rerun0");
    for (int w = 0; w < NW0; w++)
      check($sformatf("imem%0d", w), imem0[w], exp_word(BA0, w));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
